// File: rtl/sample_packetizer_pkg.sv
// Shared types and constants for the ADC sample packetizer feeding the FT232H bridge.
package sample_packetizer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEQ,
        LOAD,
        PAYLOAD,
        CSUM
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic int bytes_per_sample(input int channels, input int sample_width);
        return channels * sample_width / 8;
    endfunction

endpackage

// File: rtl/sample_packetizer.sv
// Frames multi-channel ADC sample words into SYNC/SEQ/payload/CSUM byte packets
// for the ft232h system-side AXI-Stream sink.
module sample_packetizer
    import sample_packetizer_pkg::*;
#(
    parameter int CHANNELS           = 2,
    parameter int SAMPLE_WIDTH       = 16,
    parameter int SAMPLES_PER_PACKET = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_tdata,
    input  logic                             sample_tvalid,
    output logic                             sample_tready,
    output logic [7:0]                       byte_tdata,
    output logic                             byte_tvalid,
    input  logic                             byte_tready,
    output logic                             busy
);

    localparam int WORD_W = CHANNELS * SAMPLE_WIDTH;
    localparam int BPS    = bytes_per_sample(CHANNELS, SAMPLE_WIDTH);
    localparam int CNT_W  = $clog2(SAMPLES_PER_PACKET + 1);
    localparam int IDX_W  = (BPS > 1) ? $clog2(BPS) : 1;

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES_PER_PACKET);
    localparam logic [IDX_W-1:0] LAST_BYTE   = IDX_W'(BPS - 1);

    generate
        if (SAMPLE_WIDTH % 8 != 0) begin : g_bad_width
            $error("sample_packetizer: SAMPLE_WIDTH must be a multiple of 8");
        end
        if (SAMPLES_PER_PACKET < 1) begin : g_bad_count
            $error("sample_packetizer: SAMPLES_PER_PACKET must be at least 1");
        end
    endgenerate

    state_t            state;
    logic [7:0]        seq;
    logic [7:0]        csum;
    logic [CNT_W-1:0]  sample_cnt;
    logic [IDX_W-1:0]  byte_idx;
    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] word_msb_first;
    logic [WORD_W-1:0] shift_next;

    // Channel 0 moves to the top so the word streams out MSB-first, channel by channel.
    always_comb begin
        word_msb_first = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            word_msb_first[WORD_W-1-c*SAMPLE_WIDTH -: SAMPLE_WIDTH] =
                sample_tdata[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
    end

    assign shift_next = shift_reg << 8;

    // Handshakes: a transfer happens on a rising edge where valid && ready. byte_tvalid
    // and byte_tdata are registered and held unchanged until the byte is taken;
    // sample_tready is high only in LOAD and never depends on byte_tready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            byte_tdata    <= 8'h00;
            byte_tvalid   <= 1'b0;
            sample_tready <= 1'b0;
            busy          <= 1'b0;
            seq           <= 8'h00;
            csum          <= 8'h00;
            sample_cnt    <= '0;
            byte_idx      <= '0;
            shift_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_tvalid) begin
                        state       <= SYNC;
                        byte_tdata  <= SYNC_BYTE;
                        byte_tvalid <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                SYNC: begin
                    if (byte_tready) begin
                        state      <= SEQ;
                        byte_tdata <= seq;
                    end
                end
                SEQ: begin
                    if (byte_tready) begin
                        state         <= LOAD;
                        csum          <= seq;
                        byte_tvalid   <= 1'b0;
                        sample_tready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (sample_tvalid && sample_tready) begin
                        state         <= PAYLOAD;
                        shift_reg     <= word_msb_first;
                        byte_tdata    <= word_msb_first[WORD_W-1 -: 8];
                        byte_tvalid   <= 1'b1;
                        sample_tready <= 1'b0;
                        byte_idx      <= '0;
                        sample_cnt    <= sample_cnt + CNT_W'(1);
                    end
                end
                PAYLOAD: begin
                    if (byte_tready) begin
                        csum <= csum ^ byte_tdata;
                        if (byte_idx == LAST_BYTE) begin
                            if (sample_cnt == LAST_SAMPLE) begin
                                state      <= CSUM;
                                byte_tdata <= csum ^ byte_tdata;
                            end else begin
                                state         <= LOAD;
                                byte_tvalid   <= 1'b0;
                                sample_tready <= 1'b1;
                            end
                        end else begin
                            byte_idx   <= byte_idx + IDX_W'(1);
                            shift_reg  <= shift_next;
                            byte_tdata <= shift_next[WORD_W-1 -: 8];
                        end
                    end
                end
                CSUM: begin
                    if (byte_tready) begin
                        state       <= IDLE;
                        seq         <= seq + 8'd1;
                        sample_cnt  <= '0;
                        byte_tvalid <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_packetizer.sv
// Randomized self-checking bench for sample_packetizer: a byte-level packet model
// fills an expected queue that every accepted output byte is checked against.
module tb_sample_packetizer;

    localparam int CH      = 2;
    localparam int SW      = 16;
    localparam int SPP     = 2;
    localparam int WORD_W  = CH * SW;
    localparam int BPS     = WORD_W / 8;
    localparam int PKT_LEN = 3 + SPP * BPS;

    logic              clk;
    logic              rst_n;
    logic [WORD_W-1:0] sample_tdata;
    logic              sample_tvalid;
    logic              sample_tready;
    logic [7:0]        byte_tdata;
    logic              byte_tvalid;
    logic              byte_tready;
    logic              busy;

    sample_packetizer #(
        .CHANNELS          (CH),
        .SAMPLE_WIDTH      (SW),
        .SAMPLES_PER_PACKET(SPP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tdata (sample_tdata),
        .sample_tvalid(sample_tvalid),
        .sample_tready(sample_tready),
        .byte_tdata   (byte_tdata),
        .byte_tvalid  (byte_tvalid),
        .byte_tready  (byte_tready),
        .busy         (busy)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int                n_vec = 0;
    int                n_err = 0;
    int                ready_pct;
    int                used;
    logic              rst_drive;
    logic [7:0]        seq_model;
    logic [7:0]        exp_q[$];
    logic [WORD_W-1:0] src_q[$];
    logic [WORD_W-1:0] words [SPP];
    logic [7:0]        nom_bytes [PKT_LEN];
    bit                s_fire;
    bit                hold_valid;
    logic [7:0]        hold_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: whole packets as byte lists, computed from the framing rules.
    task automatic add_packet(input logic [WORD_W-1:0] w [SPP]);
        logic [7:0] b;
        logic [7:0] cs;
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq_model);
        cs = seq_model;
        for (int s = 0; s < SPP; s++) begin
            for (int c = 0; c < CH; c++) begin
                for (int k = SW / 8 - 1; k >= 0; k--) begin
                    b = w[s][c*SW + k*8 +: 8];
                    exp_q.push_back(b);
                    cs = cs ^ b;
                end
            end
        end
        exp_q.push_back(cs);
        seq_model = seq_model + 8'd1;
    endtask

    task automatic send_packet(input logic [WORD_W-1:0] w [SPP]);
        add_packet(w);
        for (int s = 0; s < SPP; s++) src_q.push_back(w[s]);
    endtask

    // Driver + monitor: one call per clock, acting on the falling edge.
    task automatic step();
        @(negedge clk);
        if (s_fire && src_q.size() > 0) src_q.delete(0);
        if (hold_valid) begin
            check_eq("stall_valid", 32'(byte_tvalid), 32'd1);
            check_eq("stall_data", 32'(byte_tdata), 32'(hold_data));
        end
        rst_n         = rst_drive;
        byte_tready   = ($urandom_range(99) < ready_pct);
        sample_tvalid = (src_q.size() > 0);
        sample_tdata  = (src_q.size() > 0) ? src_q[0] : '0;
        s_fire        = sample_tvalid && sample_tready && rst_n;
        if (byte_tvalid && byte_tready && rst_n) begin
            if (exp_q.size() == 0) check_eq("extra_byte", 32'(exp_q.size()), 32'd1);
            else                   check_eq("byte", 32'(byte_tdata), 32'(exp_q.pop_front()));
        end
        hold_valid = byte_tvalid && !byte_tready && rst_n;
        hold_data  = byte_tdata;
    endtask

    task automatic run_until(input string tag, input int left, input int budget, output int n);
        n = 0;
        while (exp_q.size() > left && n < budget) begin
            step();
            n++;
        end
        check_eq({tag, "_done"}, 32'(exp_q.size()), 32'(left));
    endtask

    initial begin
        rst_n         = 1'b0;
        rst_drive     = 1'b0;
        sample_tvalid = 1'b0;
        sample_tdata  = '0;
        byte_tready   = 1'b0;
        ready_pct     = 100;
        seq_model     = 8'h00;
        s_fire        = 1'b0;
        hold_valid    = 1'b0;
        hold_data     = 8'h00;

        repeat (3) step();
        check_eq("rst_byte_tvalid", 32'(byte_tvalid), 32'd0);
        check_eq("rst_byte_tdata", 32'(byte_tdata), 32'h00);
        check_eq("rst_sample_tready", 32'(sample_tready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst_drive = 1'b1;

        // Nominal packet against literal bytes, full throughput
        nom_bytes = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78,
                      8'h9A, 8'hBC, 8'hDE, 8'hF1, 8'h01};
        words[0] = 32'h5678_1234;
        words[1] = 32'hDEF1_9ABC;
        for (int i = 0; i < PKT_LEN; i++) exp_q.push_back(nom_bytes[i]);
        for (int s = 0; s < SPP; s++) src_q.push_back(words[s]);
        seq_model = 8'h01;
        run_until("nominal", 0, 200, used);
        check_eq("nominal_cycles", 32'(used), 32'(4 + SPP * (BPS + 1)));

        // Same samples under random backpressure
        ready_pct = 50;
        send_packet(words);
        run_until("backpressure", 0, 500, used);

        // 257 random packets so SEQ wraps past 0xFF
        ready_pct = 85;
        for (int p = 0; p < 257; p++) begin
            for (int s = 0; s < SPP; s++) words[s] = WORD_W'($urandom());
            send_packet(words);
        end
        run_until("wrap", 0, 20000, used);

        // Input starvation between the two samples of a packet
        ready_pct = 100;
        for (int s = 0; s < SPP; s++) words[s] = WORD_W'($urandom());
        add_packet(words);
        src_q.push_back(words[0]);
        run_until("starve_first", BPS + 1, 200, used);
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("starve_tvalid", 32'(byte_tvalid), 32'd0);
            check_eq("starve_busy", 32'(busy), 32'd1);
        end
        src_q.push_back(words[1]);
        run_until("starve_done", 0, 200, used);

        // One-cycle reset after the 4th byte abandons the packet
        for (int s = 0; s < SPP; s++) words[s] = WORD_W'($urandom());
        send_packet(words);
        run_until("pre_reset", PKT_LEN - 4, 200, used);
        rst_drive = 1'b0;
        src_q.delete();
        exp_q.delete();
        step();
        rst_drive = 1'b1;
        step();
        check_eq("post_rst_tvalid", 32'(byte_tvalid), 32'd0);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        seq_model = 8'h00;
        ready_pct = 70;
        for (int s = 0; s < SPP; s++) words[s] = WORD_W'($urandom());
        send_packet(words);
        run_until("post_reset", 0, 500, used);

        repeat (5) step();
        check_eq("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sample_packetizer.md
# sample_packetizer

Frames multi-channel ADC sample words into a byte-oriented packet stream for the FT232H synchronous FIFO bridge. It sits directly upstream of `ft232h`: its byte output drives that block's system-side AXI-Stream sink. It adds a sync byte, an 8-bit sequence number and an XOR checksum so the host can detect lost or truncated packets.

## Interface
- `CHANNELS`, default 2: channels per sample word.
- `SAMPLE_WIDTH`, default 16: bits per channel. Must be a multiple of 8; an elaboration-time check fails otherwise.
- `SAMPLES_PER_PACKET`, default 4: sample words per packet. Must be ≥1.

- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst_n`  in  1  **one clock; reset is synchronous and active-low.**
- `sample_tdata`  in  CHANNELS*SAMPLE_WIDTH  channel 0 in the LSBs.
- `sample_tvalid`  in  1  a sample word is offered.
- `sample_tready`  out  1  the sample word is accepted on `tvalid && tready`.
- `byte_tdata`  out  8  packet byte; connects to the `ft232h` sink `tdata`.
- `byte_tvalid`  out  1  packet byte valid.
- `byte_tready`  in  1  downstream accepts the byte.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Packet, in order:
  - SYNC = 0xA5.
  - SEQ.
  - For each sample word in arrival order, for channel 0..CHANNELS-1, the channel's bytes, MSB first.
  - CSUM.
- Packet length = 3 + SAMPLES_PER_PACKET*CHANNELS*SAMPLE_WIDTH/8.
- CSUM = XOR of SEQ and all payload bytes. SYNC is excluded.
- SEQ is an 8-bit counter. It starts at 0 after reset, increments by 1 after each CSUM handshake, and wraps 0xFF→0x00.
- State machine:
  - IDLE: waits for `sample_tvalid`, which is observed but not consumed. On seeing it → SYNC.
  - SYNC: presents 0xA5. On handshake → SEQ.
  - SEQ: presents SEQ and seeds the checksum accumulator with SEQ. On handshake → LOAD.
  - LOAD: drives `sample_tready` = 1 and `byte_tvalid` = 0. On sample handshake, captures the word into the shift register, zeroes the byte index, increments the sample count → PAYLOAD.
  - PAYLOAD: presents the current byte and XORs it into the accumulator on handshake. After the last byte of the word: if sample count = SAMPLES_PER_PACKET → CSUM, else → LOAD.
  - CSUM: presents the accumulator. On handshake, increments SEQ, clears the sample count → IDLE.
- `sample_tready` is high only in LOAD. It is a pure function of state, with no combinational path from `byte_tready`.
- Mid-packet input starvation: the block stays in LOAD with `byte_tvalid` = 0 indefinitely. The packet is never aborted or timed out.
- Counter widths: sample count $clog2(SAMPLES_PER_PACKET+1); byte index $clog2(CHANNELS*SAMPLE_WIDTH/8).

## Timing
- Reset values: `byte_tvalid` = 0, `byte_tdata` = 0x00, `sample_tready` = 0, `busy` = 0, SEQ = 0, accumulator = 0, state = IDLE.
- Reset mid-packet abandons the partial packet. No CSUM is emitted, and the host resynchronises on the next 0xA5.
- `byte_tdata`/`byte_tvalid` are registered.
  - While `byte_tvalid && !byte_tready`, `byte_tdata` is held stable and `byte_tvalid` is not deasserted (AXI-Stream rule).
  - `byte_tvalid` never depends combinationally on `byte_tready`.
- Latencies:
  - `sample_tvalid` seen in IDLE at edge N → SYNC valid from edge N+1.
  - Sample handshake in LOAD at edge N → first payload byte valid from edge N+1.
- With `byte_tready` held high and samples always available, bytes go out one per cycle, with one bubble cycle per sample word (LOAD) and one per packet (IDLE).
- Backpressure on the last payload byte holds the state in PAYLOAD. The accumulator updates only on handshake, never on a stalled cycle.

## Structure
- Shared package `sample_packetizer_pkg` holds:
  - the state enum (IDLE, SYNC, SEQ, LOAD, PAYLOAD, CSUM);
  - `SYNC_BYTE` = 8'hA5;
  - the derived `BYTES_PER_SAMPLE` function.
- Single module, no sub-module. The shift register, counters and output register are inline.

## Test plan
All scenarios use CHANNELS=2, SAMPLE_WIDTH=16, SAMPLES_PER_PACKET=2.
- **Nominal packet.** Samples {ch0=0x1234, ch1=0x5678}, {ch0=0x9ABC, ch1=0xDEF1}, `byte_tready` = 1 → bytes A5 00 12 34 56 78 9A BC DE F1 01.
- **Backpressure.** Same stimulus, `byte_tready` toggled pseudo-randomly → identical byte sequence, no byte duplicated or lost, `byte_tdata` stable while stalled.
- **Sequence wrap.** 257 back-to-back packets → SEQ bytes 0x00…0xFF then 0x00. Every CSUM matches a scoreboard recomputation.
- **Starvation.** Deassert `sample_tvalid` for 20 cycles after the first sample → `byte_tvalid` = 0 throughout, `busy` = 1. The packet completes correctly once the second sample arrives.
- **Reset mid-packet.** `rst_n` low for one cycle after the 4th byte → the next cycle shows `byte_tvalid` = 0 and `busy` = 0. The next packet starts A5 00.
- **Downstream integration.** Drive `ft232h` plus the FT232H bus-functional model, read the PC side with `tready` = 1 → the PC stream equals the nominal byte sequence.
